// File: rtl/key_expansion.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake.
// aes_sbox is the combinational byte substitution used by SubWord.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[in_i];

endmodule

module key_expansion #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              key_ready_out,
  input  logic              round_key_ready,
  output logic              key_valid_out,
  output logic [DATA_W-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              last_round
);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  state_e            state_q;
  logic              valid_q;
  logic              ready_q;
  logic [DATA_W-1:0] key_q;
  logic [3:0]        idx_q;
  logic              last_q;

  logic [31:0]       w0, w1, w2, w3;
  logic [31:0]       rot_w;
  logic [31:0]       sub_w;
  logic [7:0]        rcon;
  logic [31:0]       t_w;
  logic [31:0]       n0, n1, n2, n3;
  logic [DATA_W-1:0] key_d;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_i  (rot_w[8*b +: 8]),
      .out_o (sub_w[8*b +: 8])
    );
  end

  // rcon[k] produces round k+1, indexed by the key currently held
  always_comb begin
    rcon = 8'h00;
    unique case (idx_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w   = sub_w ^ {rcon, 24'h0};
  assign n0    = w0 ^ t_w;
  assign n1    = w1 ^ n0;
  assign n2    = w2 ^ n1;
  assign n3    = w3 ^ n2;
  assign key_d = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      key_q   <= '0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_valid_in) begin
            state_q <= EXPAND;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            key_q   <= key_in;
            idx_q   <= 4'd0;
            last_q  <= 1'b0;
          end
        end
        EXPAND: begin
          if (round_key_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              last_q  <= 1'b0;
            end else begin
              key_q  <= key_d;
              idx_q  <= idx_q + 4'd1;
              last_q <= (idx_q == 4'd9);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready_out = ready_q;
  assign key_valid_out = valid_q;
  assign round_key     = key_q;
  assign round_idx     = idx_q;
  assign last_round    = last_q;

endmodule
